ddp_pkg_arbiter: RTL and testbench
==================================

# ddp_pkg_arbiter

Packet-atomic round-robin arbiter that shares the single packet-encapsulation FIFO write port between several DDP header generators. Each requester presents one beat per cycle (RDMAP header/ctrl + DDP header/ctrl) with DDP ctrl SOP/EOP flags. The arbiter grants one requester per packet and holds the grant from SOP to EOP so multi-piece SEND packets are never interleaved. Beats pass through one output register stage toward the FIFO under `pkgFifoFull` back-pressure.

## Interface
- `NUM_REQ`, 4, number of requesters (2..2^`REQ_ID_W`)
- `REQ_ID_W`, 2, width of requester index
- `clock` input 1 core clock
- `reset` input 1 asynchronous, active-low reset
- `reqValid` input NUM_REQ per-requester beat valid
- `reqRdmapHeader` input 56*NUM_REQ requester i at [56i+55:56i]
- `reqRdmapCtrl` input 8*NUM_REQ requester i at [8i+7:8i]
- `reqDdpHeader` input 16*NUM_REQ requester i at [16i+15:16i]
- `reqDdpCtrl` input 8*NUM_REQ bit 7 = SOP, bit 6 = EOP
- `reqReady` output NUM_REQ beat accepted when `reqValid[i] & reqReady[i]`
- `pkgFifoFull` input 1 encapsulation FIFO full
- `pkgPush` output 1 push strobe to FIFO
- `pkgRdmapHeader` output 56, `pkgRdmapCtrl` output 8, `pkgDdpHeader` output 16, `pkgDdpCtrl` output 8: registered beat
- `pkgSrcId` output REQ_ID_W requester index of the registered beat
- `locked` output 1 arbiter is inside a multi-beat packet
- `protoErr` output 1 sticky protocol-error flag
- `pktCount` output 16 completed packets (EOP beats pushed), wraps

## Operation
- Output stage: register `outValid` plus data. `pkgPush = outValid & ~pkgFifoFull`. `canLoad = ~outValid | pkgPush`. When a beat is accepted, data and `pkgSrcId` load and `outValid` = 1. When `pkgPush` with no accept, `outValid` = 0.
- States: IDLE, LOCK (owner register `ownerId`).
- IDLE: winner = first i with `reqValid[i]`, searching from `rrPtr` upward modulo NUM_REQ. `reqReady[winner] = canLoad`, all others 0.
  - Accepted beat with SOP & ~EOP: go to LOCK, `ownerId` = winner.
  - Accepted beat with SOP & EOP (REQ/ACK single beat): stay IDLE, `rrPtr` = winner+1 mod NUM_REQ.
  - Accepted beat without SOP: set `protoErr`. Treat as a single-beat packet: stay IDLE and advance `rrPtr`.
- LOCK: `reqReady[ownerId] = canLoad`, all others 0. Owner deasserting valid holds the lock indefinitely; there is no timeout.
  - Owner beat with EOP accepted: go to IDLE, `rrPtr` = ownerId+1 mod NUM_REQ.
  - Owner beat with SOP (and no EOP) while in LOCK: set `protoErr`, keep the beat, stay locked.
- `reqReady` is combinational from state, `rrPtr`, `reqValid` and `canLoad`. It never depends on a requester's own ctrl bits.
- `locked` = (state == LOCK).
- `pktCount` increments by 1 on each `pkgPush` with `pkgDdpCtrl[6]` = 1. It wraps 16'hFFFF → 0.
- `protoErr` clears only on reset.

## Timing
- Reset (async assert, sync-released logic): state IDLE, `rrPtr` 0, `ownerId` 0, `outValid` 0, `pkgPush` 0, all `pkg*` data 0, `pkgSrcId` 0, `locked` 0, `protoErr` 0, `pktCount` 0, `reqReady` 0 when all `reqValid` = 0.
- Reset mid-packet discards the lock and the registered beat. No push may occur while reset is asserted.
- Latency: a beat accepted in cycle N is on `pkg*` in cycle N+1 and pushes in N+1 if `~pkgFifoFull`.
- Throughput: 1 beat/cycle sustained while `pkgFifoFull` = 0.
- Simultaneous push and accept in the same cycle: the register reloads and `outValid` stays 1, with no bubble.
- `pkgFifoFull` = 1 with `outValid` = 1: `canLoad` = 0, all `reqReady` = 0, and the registered beat is held stable.
- The state transition, `rrPtr` update and `protoErr` set all take effect at the clock edge that accepts the beat. A new grant can be issued the cycle after an EOP accept.

## Test plan
- Single-beat fairness: all 4 requesters hold SOP|EOP beats continuously (`reqDdpCtrl` 8'hC0), `pkgFifoFull` = 0 → `pkgSrcId` sequence 0,1,2,3,0,…; `pktCount` = 8 after 8 pushes.
- Atomic multi-beat packet: req1 sends 3 beats (8'h80, 8'h00, 8'h40) while req0/req2 are valid → 3 consecutive pushes with `pkgSrcId` = 1, `locked` = 1 throughout, then req2 is granted next.
- Back-pressure: `pkgFifoFull` = 1 for 5 cycles with `outValid` = 1 → `pkgPush` = 0, `reqReady` = 0, data stable; on release, push the held beat, then resume 1 beat/cycle.
- Owner stall: req3 in LOCK drops `reqValid` for 4 cycles while req0 is valid → req0 is never ready; req3 resumes and the EOP completes; then req0 is granted.
- Protocol errors: a beat with ctrl 8'h00 while IDLE → `protoErr` = 1 and the beat is still pushed. Reset → `protoErr` = 0 and `pktCount` = 0.
- Reset mid-packet: assert reset during LOCK with `outValid` = 1 → no push, `locked` = 0; after release, a new requester is granted starting from `rrPtr` = 0.

Source files
------------

// File: rtl/ddp_pkg_arbiter.sv
// ---------------------------------------------------------------------------
// ddp_pkg_arbiter
//
// Packet-atomic round-robin arbiter in front of the packet-encapsulation FIFO
// write port. Several DDP header generators each offer one beat per cycle.
// A requester is granted on a packet boundary and keeps the grant from SOP
// to EOP, so multi-beat SEND packets are never interleaved. The granted beat
// passes through one output register toward the FIFO under pkgFifoFull
// back-pressure.
//
// Ports:
//   clock, reset         core clock, asynchronous active-low reset
//   reqValid             per-requester beat valid
//   reqRdmapHeader       56 bits per requester, requester i at [56i+55:56i]
//   reqRdmapCtrl         8 bits per requester
//   reqDdpHeader         16 bits per requester
//   reqDdpCtrl           8 bits per requester, bit 7 = SOP, bit 6 = EOP
//   reqReady             per-requester accept (beat taken on valid & ready)
//   pkgFifoFull          FIFO full back-pressure
//   pkgPush              push strobe to the FIFO
//   pkgRdmapHeader/Ctrl  registered beat, RDMAP part
//   pkgDdpHeader/Ctrl    registered beat, DDP part
//   pkgSrcId             requester index of the registered beat
//   locked               arbiter is inside a multi-beat packet
//   protoErr             sticky protocol-error flag
//   pktCount             EOP beats pushed, wraps at 16 bits
// ---------------------------------------------------------------------------
module ddp_pkg_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int REQ_ID_W = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      reqValid,
    input  logic [56*NUM_REQ-1:0]   reqRdmapHeader,
    input  logic [8*NUM_REQ-1:0]    reqRdmapCtrl,
    input  logic [16*NUM_REQ-1:0]   reqDdpHeader,
    input  logic [8*NUM_REQ-1:0]    reqDdpCtrl,
    output logic [NUM_REQ-1:0]      reqReady,
    input  logic                    pkgFifoFull,
    output logic                    pkgPush,
    output logic [55:0]             pkgRdmapHeader,
    output logic [7:0]              pkgRdmapCtrl,
    output logic [15:0]             pkgDdpHeader,
    output logic [7:0]              pkgDdpCtrl,
    output logic [REQ_ID_W-1:0]     pkgSrcId,
    output logic                    locked,
    output logic                    protoErr,
    output logic [15:0]             pktCount
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    // Architectural state
    logic [0:0]          state_reg;
    logic [REQ_ID_W-1:0] rr_ptr_reg;
    logic [REQ_ID_W-1:0] owner_id_reg;
    logic                out_valid_reg;
    logic [55:0]         rdmap_hdr_reg;
    logic [7:0]          rdmap_ctrl_reg;
    logic [15:0]         ddp_hdr_reg;
    logic [7:0]          ddp_ctrl_reg;
    logic [REQ_ID_W-1:0] src_id_reg;
    logic                proto_err_reg;
    logic [15:0]         pkt_count_reg;

    // Per-requester views of the packed input buses
    logic [55:0] req_rdmap_hdr  [NUM_REQ];
    logic [7:0]  req_rdmap_ctrl [NUM_REQ];
    logic [15:0] req_ddp_hdr    [NUM_REQ];
    logic [7:0]  req_ddp_ctrl   [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_rdmap_hdr[gi]  = reqRdmapHeader[56*gi +: 56];
            assign req_rdmap_ctrl[gi] = reqRdmapCtrl[8*gi +: 8];
            assign req_ddp_hdr[gi]    = reqDdpHeader[16*gi +: 16];
            assign req_ddp_ctrl[gi]   = reqDdpCtrl[8*gi +: 8];
        end
    endgenerate

    // Output stage handshake: the register may load when empty or draining
    // this very cycle, which gives back-to-back beats with no bubble.
    logic push;
    logic can_load;
    assign push     = out_valid_reg & ~pkgFifoFull;
    assign can_load = ~out_valid_reg | push;

    // Round-robin search starting at rr_ptr_reg
    logic [REQ_ID_W-1:0] winner;
    logic                winner_found;
    always_comb begin
        int idx;
        winner       = '0;
        winner_found = 1'b0;
        idx          = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!winner_found && reqValid[idx]) begin
                winner_found = 1'b1;
                winner       = REQ_ID_W'(idx);
            end
        end
    end

    // Selected requester: the owner while locked, otherwise the RR winner
    logic                sel_valid;
    logic [REQ_ID_W-1:0] sel_id;
    logic                accept;
    logic                sel_sop;
    logic                sel_eop;

    assign sel_id    = (state_reg == ST_LOCK) ? owner_id_reg : winner;
    assign sel_valid = (state_reg == ST_LOCK) ? reqValid[owner_id_reg] : winner_found;
    assign accept    = sel_valid & can_load;
    assign sel_sop   = req_ddp_ctrl[sel_id][7];
    assign sel_eop   = req_ddp_ctrl[sel_id][6];

    // Ready depends only on state, pointer, valids and can_load. While locked
    // the owner sees ready even if it is idle, so it can resume at any time.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign reqReady[gi] = can_load &
                ((state_reg == ST_LOCK) ? (int'(owner_id_reg) == gi)
                                        : (winner_found && (int'(winner) == gi)));
        end
    endgenerate

    function automatic logic [REQ_ID_W-1:0] next_id(input logic [REQ_ID_W-1:0] id);
        return (int'(id) == NUM_REQ - 1) ? '0 : id + 1'b1;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            rr_ptr_reg     <= '0;
            owner_id_reg   <= '0;
            out_valid_reg  <= 1'b0;
            rdmap_hdr_reg  <= '0;
            rdmap_ctrl_reg <= '0;
            ddp_hdr_reg    <= '0;
            ddp_ctrl_reg   <= '0;
            src_id_reg     <= '0;
            proto_err_reg  <= 1'b0;
            pkt_count_reg  <= '0;
        end else begin
            // Output register
            if (accept) begin
                out_valid_reg  <= 1'b1;
                rdmap_hdr_reg  <= req_rdmap_hdr[sel_id];
                rdmap_ctrl_reg <= req_rdmap_ctrl[sel_id];
                ddp_hdr_reg    <= req_ddp_hdr[sel_id];
                ddp_ctrl_reg   <= req_ddp_ctrl[sel_id];
                src_id_reg     <= sel_id;
            end else if (push) begin
                out_valid_reg <= 1'b0;
            end

            if (push && ddp_ctrl_reg[6]) begin
                pkt_count_reg <= pkt_count_reg + 16'd1;
            end

            // Packet FSM
            if (accept) begin
                case (state_reg)
                    ST_IDLE: begin
                        if (sel_sop && !sel_eop) begin
                            state_reg    <= ST_LOCK;
                            owner_id_reg <= sel_id;
                        end else begin
                            // Single-beat packet, or a stray beat without
                            // SOP that is flagged and treated as one.
                            rr_ptr_reg <= next_id(sel_id);
                            if (!sel_sop) begin
                                proto_err_reg <= 1'b1;
                            end
                        end
                    end
                    ST_LOCK: begin
                        if (sel_eop) begin
                            state_reg  <= ST_IDLE;
                            rr_ptr_reg <= next_id(owner_id_reg);
                        end else if (sel_sop) begin
                            proto_err_reg <= 1'b1;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign pkgPush        = push;
    assign pkgRdmapHeader = rdmap_hdr_reg;
    assign pkgRdmapCtrl   = rdmap_ctrl_reg;
    assign pkgDdpHeader   = ddp_hdr_reg;
    assign pkgDdpCtrl     = ddp_ctrl_reg;
    assign pkgSrcId       = src_id_reg;
    assign locked         = (state_reg == ST_LOCK);
    assign protoErr       = proto_err_reg;
    assign pktCount       = pkt_count_reg;

endmodule

// File: tb/tb_ddp_pkg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ddp_pkg_arbiter
//
// Directed bench for ddp_pkg_arbiter. A table of per-cycle vectors covers
// round-robin fairness, an atomic 3-beat packet, back-pressure, an owner
// stall and a stray non-SOP beat. Hand-written sequences cover reset values,
// reset in the middle of a packet and SOP inside a locked packet.
// ---------------------------------------------------------------------------
module tb_ddp_pkg_arbiter;

    logic          clock;
    logic          reset;
    logic [3:0]    reqValid;
    logic [223:0]  reqRdmapHeader;
    logic [31:0]   reqRdmapCtrl;
    logic [63:0]   reqDdpHeader;
    logic [31:0]   reqDdpCtrl;
    logic [3:0]    reqReady;
    logic          pkgFifoFull;
    logic          pkgPush;
    logic [55:0]   pkgRdmapHeader;
    logic [7:0]    pkgRdmapCtrl;
    logic [15:0]   pkgDdpHeader;
    logic [7:0]    pkgDdpCtrl;
    logic [1:0]    pkgSrcId;
    logic          locked;
    logic          protoErr;
    logic [15:0]   pktCount;

    ddp_pkg_arbiter #(.NUM_REQ(4), .REQ_ID_W(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .reqValid       (reqValid),
        .reqRdmapHeader (reqRdmapHeader),
        .reqRdmapCtrl   (reqRdmapCtrl),
        .reqDdpHeader   (reqDdpHeader),
        .reqDdpCtrl     (reqDdpCtrl),
        .reqReady       (reqReady),
        .pkgFifoFull    (pkgFifoFull),
        .pkgPush        (pkgPush),
        .pkgRdmapHeader (pkgRdmapHeader),
        .pkgRdmapCtrl   (pkgRdmapCtrl),
        .pkgDdpHeader   (pkgDdpHeader),
        .pkgDdpCtrl     (pkgDdpCtrl),
        .pkgSrcId       (pkgSrcId),
        .locked         (locked),
        .protoErr       (protoErr),
        .pktCount       (pktCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] ctrl;   // {ctrl3, ctrl2, ctrl1, ctrl0}
        logic        full;
        logic [3:0]  ready;  // expected before the edge
        logic        push;   // expected after the edge
        logic [1:0]  src;
        logic        lck;
        logic        err;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [3:0] valid, input logic [31:0] ctrl,
                                input logic full, input logic [3:0] ready,
                                input logic push, input logic [1:0] src,
                                input logic lck, input logic err,
                                input logic [15:0] cnt);
        vec_t v;
        v.valid = valid; v.ctrl = ctrl; v.full = full; v.ready = ready;
        v.push = push; v.src = src; v.lck = lck; v.err = err; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [55:0] exp_hdr(input logic [1:0] src);
        logic [55:0] base;
        base = 56'h01010101010101;
        return base * 56'(src + 3'd1);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset       = 1'b0;
        reqValid    = '0;
        reqDdpCtrl  = '0;
        pkgFifoFull = 1'b0;
        for (int i = 0; i < 4; i++) begin
            reqRdmapHeader[56*i +: 56] = exp_hdr(2'(i));
            reqRdmapCtrl[8*i +: 8]     = 8'(8'h10 + i);
            reqDdpHeader[16*i +: 16]   = 16'(16'hD000 + i);
        end

        // Vectors: valid, ctrl, full, ready, push, src, locked, err, cnt
        // Fairness: all four send single-beat packets
        add(4'hF, 32'hC0C0C0C0, 0, 4'h1, 1, 0, 0, 0, 0);
        add(4'hF, 32'hC0C0C0C0, 0, 4'h2, 1, 1, 0, 0, 1);
        add(4'hF, 32'hC0C0C0C0, 0, 4'h4, 1, 2, 0, 0, 2);
        add(4'hF, 32'hC0C0C0C0, 0, 4'h8, 1, 3, 0, 0, 3);
        add(4'hF, 32'hC0C0C0C0, 0, 4'h1, 1, 0, 0, 0, 4);
        add(4'hF, 32'hC0C0C0C0, 0, 4'h2, 1, 1, 0, 0, 5);
        add(4'hF, 32'hC0C0C0C0, 0, 4'h4, 1, 2, 0, 0, 6);
        add(4'hF, 32'hC0C0C0C0, 0, 4'h8, 1, 3, 0, 0, 7);
        add(4'h0, 32'hC0C0C0C0, 0, 4'h0, 0, 3, 0, 0, 8);
        // Atomic 3-beat packet from req1 with req0/req2 competing
        add(4'h1, 32'hC0C0C0C0, 0, 4'h1, 1, 0, 0, 0, 8);
        add(4'h7, 32'hC0C080C0, 0, 4'h2, 1, 1, 1, 0, 9);
        add(4'h7, 32'hC0C000C0, 0, 4'h2, 1, 1, 1, 0, 9);
        add(4'h7, 32'hC0C040C0, 0, 4'h2, 1, 1, 0, 0, 9);
        add(4'h5, 32'hC0C0C0C0, 0, 4'h4, 1, 2, 0, 0, 10);
        add(4'h0, 32'hC0C0C0C0, 0, 4'h0, 0, 2, 0, 0, 11);
        // Back-pressure for 5 cycles, then release and stream
        add(4'h1, 32'hC0C0C0C0, 0, 4'h1, 1, 0, 0, 0, 11);
        add(4'h2, 32'hC0C0C0C0, 1, 4'h0, 0, 0, 0, 0, 11);
        add(4'h2, 32'hC0C0C0C0, 1, 4'h0, 0, 0, 0, 0, 11);
        add(4'h2, 32'hC0C0C0C0, 1, 4'h0, 0, 0, 0, 0, 11);
        add(4'h2, 32'hC0C0C0C0, 1, 4'h0, 0, 0, 0, 0, 11);
        add(4'h2, 32'hC0C0C0C0, 1, 4'h0, 0, 0, 0, 0, 11);
        add(4'h2, 32'hC0C0C0C0, 0, 4'h2, 1, 1, 0, 0, 12);
        add(4'h2, 32'hC0C0C0C0, 0, 4'h2, 1, 1, 0, 0, 13);
        add(4'h0, 32'hC0C0C0C0, 0, 4'h0, 0, 1, 0, 0, 14);
        // Owner stall: req3 locks, goes idle 4 cycles while req0 waits
        add(4'h8, 32'h80C0C0C0, 0, 4'h8, 1, 3, 1, 0, 14);
        add(4'h1, 32'hC0C0C0C0, 0, 4'h8, 0, 3, 1, 0, 14);
        add(4'h1, 32'hC0C0C0C0, 0, 4'h8, 0, 3, 1, 0, 14);
        add(4'h1, 32'hC0C0C0C0, 0, 4'h8, 0, 3, 1, 0, 14);
        add(4'h1, 32'hC0C0C0C0, 0, 4'h8, 0, 3, 1, 0, 14);
        add(4'h9, 32'h40C0C0C0, 0, 4'h8, 1, 3, 0, 0, 14);
        add(4'h1, 32'hC0C0C0C0, 0, 4'h1, 1, 0, 0, 0, 15);
        add(4'h0, 32'hC0C0C0C0, 0, 4'h0, 0, 0, 0, 0, 16);
        // Stray beat without SOP while idle
        add(4'h4, 32'hC000C0C0, 0, 4'h4, 1, 2, 0, 1, 16);
        add(4'h0, 32'hC000C0C0, 0, 4'h0, 0, 2, 0, 1, 16);

        // Reset values
        repeat (3) @(posedge clock);
        #1;
        check("rst_push",   pkgPush, 0);
        check("rst_ready",  reqReady, 0);
        check("rst_hdr",    pkgRdmapHeader, 0);
        check("rst_rctl",   pkgRdmapCtrl, 0);
        check("rst_dhdr",   pkgDdpHeader, 0);
        check("rst_dctl",   pkgDdpCtrl, 0);
        check("rst_src",    pkgSrcId, 0);
        check("rst_locked", locked, 0);
        check("rst_err",    protoErr, 0);
        check("rst_cnt",    pktCount, 0);
        reset = 1'b1;

        // Table-driven section
        foreach (vecs[n]) begin
            reqValid    = vecs[n].valid;
            reqDdpCtrl  = vecs[n].ctrl;
            pkgFifoFull = vecs[n].full;
            #1;
            check($sformatf("v%0d_ready", n), reqReady, vecs[n].ready);
            step();
            check($sformatf("v%0d_push", n),   pkgPush, vecs[n].push);
            check($sformatf("v%0d_src", n),    pkgSrcId, vecs[n].src);
            check($sformatf("v%0d_dhdr", n),   pkgDdpHeader, 16'hD000 + 16'(vecs[n].src));
            check($sformatf("v%0d_rhdr", n),   pkgRdmapHeader, exp_hdr(vecs[n].src));
            check($sformatf("v%0d_locked", n), locked, vecs[n].lck);
            check($sformatf("v%0d_err", n),    protoErr, vecs[n].err);
            check($sformatf("v%0d_cnt", n),    pktCount, vecs[n].cnt);
            $display("[TB] vec %0d valid=%h ready=%h push=%0b src=%0d locked=%0b err=%0b cnt=%0d",
                     n, vecs[n].valid, reqReady, pkgPush, pkgSrcId, locked, protoErr, pktCount);
        end

        // Reset mid-packet: req1 locks (pointer at 3 searches 3,0,1)
        reqValid   = 4'h2;
        reqDdpCtrl = 32'hC0C080C0;
        #1;
        check("mid_ready", reqReady, 4'h2);
        step();
        check("mid_locked", locked, 1);
        check("mid_push",   pkgPush, 1);
        $display("[TB] mid-packet beat src=%0d locked=%0b", pkgSrcId, locked);
        reset = 1'b0;
        #1;
        check("mid_rst_push",   pkgPush, 0);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_err",    protoErr, 0);
        check("mid_rst_cnt",    pktCount, 0);
        reqValid   = 4'hC;
        reqDdpCtrl = 32'hC0C0C0C0;
        for (int c = 0; c < 2; c++) begin
            step();
            check($sformatf("in_rst_push%0d", c), pkgPush, 0);
        end
        reset = 1'b1;
        #1;
        // Pointer is back at 0, so req2 wins over req3
        check("post_rst_ready", reqReady, 4'h4);
        step();
        check("post_rst_push",   pkgPush, 1);
        check("post_rst_src",    pkgSrcId, 2);
        check("post_rst_locked", locked, 0);
        $display("[TB] post-reset grant src=%0d push=%0b", pkgSrcId, pkgPush);

        // SOP inside a locked packet (pointer now 3 -> req0 wins)
        reqValid   = 4'h1;
        reqDdpCtrl = 32'hC0C0C080;
        step();
        check("lsop_locked0", locked, 1);
        check("lsop_err0",    protoErr, 0);
        check("lsop_src0",    pkgSrcId, 0);
        step();
        check("lsop_err1",    protoErr, 1);
        check("lsop_locked1", locked, 1);
        check("lsop_push1",   pkgPush, 1);
        reqDdpCtrl = 32'hC0C0C040;
        step();
        check("lsop_locked2", locked, 0);
        check("lsop_cnt",     pktCount, 1);
        $display("[TB] locked-SOP sequence err=%0b cnt=%0d", protoErr, pktCount);
        reqValid = 4'h0;
        step();
        check("lsop_cnt_end", pktCount, 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
